// File: rtl/tpu_slot_timer.sv
// -----------------------------------------------------------------------------
// tpu_slot_timer
//
// Timebase for the TPU gated-clock generator. A free-running slot counter is
// split into a slot index (upper bits) and an offset within the slot (lower
// OFF_BITS bits). The frame length is programmable through last_slot. Each
// frame wrap pulses frame_wrap and sets a sticky interrupt flag. The flag is
// masked into tpu_irq. TX and RX slot windows and their boundary strobes are
// decoded from the registered counter.
//
// Ports
//   sys_clock      : system clock, rising edge
//   reset          : synchronous active-low reset
//   tpu_control    : [0] rsttpu, [1] txslot_en, [2] rxslot_en,
//                    [3] timerintmsk (1 = IRQ enabled), [7:4] not used here
//   tx_slot        : selected TX slot ([7] ignored)
//   rx_slot        : selected RX slot ([7] ignored)
//   last_slot      : index of the final slot in the frame
//   int_clr        : single-cycle pulse that clears int_flag
//   counter        : registered slot counter {slot, offset}
//   tx_window      : counter is inside the enabled TX slot
//   rx_window      : counter is inside the enabled RX slot
//   tx_slot_start  : first cycle of the TX window
//   rx_slot_end    : last cycle of the RX window
//   frame_wrap     : pulse in the first cycle of every new frame
//   int_flag       : sticky frame-wrap flag
//   tpu_irq        : int_flag gated by timerintmsk
// -----------------------------------------------------------------------------
module tpu_slot_timer #(
  parameter int OFF_BITS = 9,
  parameter int CNT_BITS = 16
) (
  input  logic                         sys_clock,
  input  logic                         reset,
  input  logic [7:0]                   tpu_control,
  input  logic [7:0]                   tx_slot,
  input  logic [7:0]                   rx_slot,
  input  logic [CNT_BITS-OFF_BITS-1:0] last_slot,
  input  logic                         int_clr,
  output logic [CNT_BITS-1:0]          counter,
  output logic                         tx_window,
  output logic                         rx_window,
  output logic                         tx_slot_start,
  output logic                         rx_slot_end,
  output logic                         frame_wrap,
  output logic                         int_flag,
  output logic                         tpu_irq
);

  localparam int SLOT_BITS = CNT_BITS - OFF_BITS;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   counter_q, counter_d;
  logic                  frame_wrap_q, frame_wrap_d;
  logic                  int_flag_q, int_flag_d;

  logic                  rsttpu;
  logic                  running;
  logic [SLOT_BITS-1:0]  slot_idx;
  logic [OFF_BITS-1:0]   slot_off;
  logic                  slot_last_cycle;
  logic                  wrap;

  assign rsttpu          = tpu_control[0];
  assign running         = (state_q == RUN);
  assign slot_idx        = counter_q[CNT_BITS-1:OFF_BITS];
  assign slot_off        = counter_q[OFF_BITS-1:0];
  assign slot_last_cycle = (slot_off == {OFF_BITS{1'b1}});

  // The all-ones term lets the counter roll over on its own if last_slot is
  // lowered below the current slot mid-frame.
  assign wrap = ((slot_idx == last_slot) && slot_last_cycle) ||
                (counter_q == {CNT_BITS{1'b1}});

  // Next-state logic.
  // NOTE: every signal driven here gets a default on entry, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    frame_wrap_d = 1'b0;
    int_flag_d   = int_flag_q;

    unique case (state_q)
      HALT: begin
        // Counter stays 0 on the start edge, so the first RUN cycle reads 0.
        counter_d = '0;
        if (!rsttpu) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (rsttpu) begin
          state_d   = HALT;
          counter_d = '0;
        end else if (wrap) begin
          counter_d    = '0;
          frame_wrap_d = 1'b1;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: begin
        state_d   = HALT;
        counter_d = '0;
      end
    endcase

    // Set has priority over a coincident host clear.
    if (int_clr) begin
      int_flag_d = 1'b0;
    end
    if (frame_wrap_d) begin
      int_flag_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      state_q      <= HALT;
      counter_q    <= '0;
      frame_wrap_q <= 1'b0;
      int_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      frame_wrap_q <= frame_wrap_d;
      int_flag_q   <= int_flag_d;
    end
  end

  // Window decode runs straight from the registered state. Enables and slot
  // selects therefore act in the same cycle they change.
  assign tx_window     = running && tpu_control[1] && (slot_idx == tx_slot[SLOT_BITS-1:0]);
  assign rx_window     = running && tpu_control[2] && (slot_idx == rx_slot[SLOT_BITS-1:0]);
  assign tx_slot_start = tx_window && (slot_off == '0);
  assign rx_slot_end   = rx_window && slot_last_cycle;

  assign counter    = counter_q;
  assign frame_wrap = frame_wrap_q;
  assign int_flag   = int_flag_q;
  assign tpu_irq    = int_flag_q && tpu_control[3];

  // Register-map bits that have no function in this block.
  logic unused_bits;
  assign unused_bits = ^{tpu_control[7:4], tx_slot[7], rx_slot[7]};

endmodule

// File: tb/tb_tpu_slot_timer.sv
// -----------------------------------------------------------------------------
// tb_tpu_slot_timer
//
// Self-checking bench for tpu_slot_timer. It has three parts:
//   - a table of single-cycle vectors for reset and start-up,
//   - hand-written sequences for the frame, window, interrupt and halt corners,
//   - a randomized phase.
// A frame-level reference model tracks the expected behaviour throughout. It
// keeps a running flag, an integer cycle position and the frame length
// (last_slot+1)*512.
// -----------------------------------------------------------------------------
module tb_tpu_slot_timer;

  logic        sys_clock = 1'b0;
  logic        rst_n     = 1'b0;
  logic [7:0]  tpu_control = 8'h00;
  logic [7:0]  tx_slot   = 8'h00;
  logic [7:0]  rx_slot   = 8'h00;
  logic [6:0]  last_slot = 7'd0;
  logic        int_clr   = 1'b0;

  logic [15:0] counter;
  logic        tx_window, rx_window, tx_slot_start, rx_slot_end;
  logic        frame_wrap, int_flag, tpu_irq;

  int n_checks = 0;
  int n_errors = 0;

  tpu_slot_timer dut (
    .sys_clock     (sys_clock),
    .reset         (rst_n),
    .tpu_control   (tpu_control),
    .tx_slot       (tx_slot),
    .rx_slot       (rx_slot),
    .last_slot     (last_slot),
    .int_clr       (int_clr),
    .counter       (counter),
    .tx_window     (tx_window),
    .rx_window     (rx_window),
    .tx_slot_start (tx_slot_start),
    .rx_slot_end   (rx_slot_end),
    .frame_wrap    (frame_wrap),
    .int_flag      (int_flag),
    .tpu_irq       (tpu_irq)
  );

  always #5 sys_clock = ~sys_clock;

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  bit m_run  = 1'b0;
  int m_pos  = 0;     // cycle position within the 65536-cycle counter space
  bit m_wrap = 1'b0;
  bit m_flag = 1'b0;

  function automatic int frame_len(input logic [6:0] ls);
    return (int'(ls) + 1) * 512;
  endfunction

  // Advance the model by one clock edge, using the inputs as the DUT sees them.
  task automatic model_edge();
    bit stop;
    bit end_of_frame;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_wrap = 0; m_flag = 0;
    end else begin
      stop         = tpu_control[0];
      end_of_frame = m_run && !stop &&
                     (m_pos == frame_len(last_slot) - 1 || m_pos == 65535);
      if (end_of_frame)  m_flag = 1;
      else if (int_clr)  m_flag = 0;
      m_wrap = end_of_frame;
      if (!m_run) begin
        m_pos = 0;
        m_run = !stop;
      end else if (stop) begin
        m_run = 0;
        m_pos = 0;
      end else begin
        m_pos = end_of_frame ? 0 : m_pos + 1;
      end
    end
  endtask

  task automatic check_model();
    bit tx_w, rx_w;
    tx_w = m_run && tpu_control[1] && ((m_pos / 512) == int'(tx_slot % 128));
    rx_w = m_run && tpu_control[2] && ((m_pos / 512) == int'(rx_slot % 128));
    check("m_counter",    32'(counter),       32'(m_pos));
    check("m_tx_window",  32'(tx_window),     32'(tx_w));
    check("m_rx_window",  32'(rx_window),     32'(rx_w));
    check("m_tx_start",   32'(tx_slot_start), 32'(tx_w && (m_pos % 512 == 0)));
    check("m_rx_end",     32'(rx_slot_end),   32'(rx_w && (m_pos % 512 == 511)));
    check("m_frame_wrap", 32'(frame_wrap),    32'(m_wrap));
    check("m_int_flag",   32'(int_flag),      32'(m_flag));
    check("m_tpu_irq",    32'(tpu_irq),       32'(m_flag && tpu_control[3]));
  endtask

  // One clock edge: the model steps with the DUT, and outputs are sampled 1
  // time unit later.
  task automatic tick();
    @(posedge sys_clock);
    model_edge();
    #1;
  endtask

  task automatic step();
    tick();
    check_model();
  endtask

  // Run until the counter reaches target, up to budget cycles.
  task automatic wait_for(input logic [15:0] target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (counter === target) break;
      step();
    end
    check(name, 32'(counter), 32'(target));
  endtask

  // -------------------------------------------------------------- vectors
  typedef struct {
    logic        rst_n;
    logic [7:0]  ctrl;
    logic [15:0] exp_cnt;
    logic        exp_tx_w;
    logic        exp_rx_w;
    logic        exp_tx_start;
    logic        exp_fw;
  } vec_t;

  vec_t vecs[8];

  int tx_cnt, rx_cnt, st_cnt, end_cnt;
  logic [15:0] st_at, end_at, tx_first, tx_last;

  initial begin
    // Reset and start-up. Slot 0 is selected with both enables on: both
    // windows must stay low during reset and open as soon as RUN begins.
    vecs[0] = '{1'b0, 8'h06, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h06, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h06, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h06, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h06, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h06, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h07, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h07, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

    #2;
    for (int i = 0; i < 8; i++) begin
      rst_n       = vecs[i].rst_n;
      tpu_control = vecs[i].ctrl;
      tick();
      check($sformatf("v%0d_counter", i),   32'(counter),       32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_tx_window", i), 32'(tx_window),     32'(vecs[i].exp_tx_w));
      check($sformatf("v%0d_rx_window", i), 32'(rx_window),     32'(vecs[i].exp_rx_w));
      check($sformatf("v%0d_tx_start", i),  32'(tx_slot_start), 32'(vecs[i].exp_tx_start));
      check($sformatf("v%0d_rx_end", i),    32'(rx_slot_end),   32'(1'b0));
      check($sformatf("v%0d_frame_wrap", i),32'(frame_wrap),    32'(vecs[i].exp_fw));
      check($sformatf("v%0d_int_flag", i),  32'(int_flag),      32'(1'b0));
      check($sformatf("v%0d_tpu_irq", i),   32'(tpu_irq),       32'(1'b0));
    end

    // Short frame with last_slot=1: wrap after 1024 cycles.
    last_slot   = 7'd1;
    tpu_control = 8'h08;
    step();
    check("sf_start_cnt", 32'(counter), 32'h0);
    for (int i = 0; i < 1023; i++) step();
    check("sf_last_cnt", 32'(counter), 32'h3FF);
    check("sf_no_wrap_yet", 32'(frame_wrap), 32'h0);
    step();
    check("sf_wrap_cnt", 32'(counter), 32'h0);
    check("sf_wrap_pulse", 32'(frame_wrap), 32'h1);
    check("sf_flag_set", 32'(int_flag), 32'h1);
    check("sf_irq_set", 32'(tpu_irq), 32'h1);
    step();
    check("sf_wrap_one_cycle", 32'(frame_wrap), 32'h0);
    check("sf_flag_sticky", 32'(int_flag), 32'h1);
    tpu_control = 8'h00;
    #1;
    check("sf_irq_masked", 32'(tpu_irq), 32'h0);
    tpu_control = 8'h08;
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
    check("sf_flag_cleared", 32'(int_flag), 32'h0);
    check("sf_irq_cleared", 32'(tpu_irq), 32'h0);

    // Set/clear collision on the wrap edge: set wins.
    wait_for(16'h03FF, 2000, "col_reach_3ff");
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
    check("col_flag_kept", 32'(int_flag), 32'h1);
    check("col_wrap", 32'(frame_wrap), 32'h1);

    // Windows: last_slot=3, TX slot 2 (bit7 set, ignored), RX slot 2.
    tpu_control = 8'h01;
    step();
    last_slot = 7'd3;
    tx_slot   = 8'h82;
    rx_slot   = 8'h02;
    for (int pass = 0; pass < 2; pass++) begin
      tpu_control = (pass == 0) ? 8'h06 : 8'h04;
      if (pass == 0) step();   // start edge, counter reads 0
      tx_cnt = 0; rx_cnt = 0; st_cnt = 0; end_cnt = 0;
      st_at = 16'hxxxx; end_at = 16'hxxxx; tx_first = 16'hxxxx; tx_last = 16'hxxxx;
      for (int i = 0; i < 2048; i++) begin
        if (tx_window) begin
          if (tx_cnt == 0) tx_first = counter;
          tx_last = counter;
          tx_cnt++;
        end
        if (rx_window) rx_cnt++;
        if (tx_slot_start) begin st_cnt++; st_at = counter; end
        if (rx_slot_end)   begin end_cnt++; end_at = counter; end
        step();
      end
      if (pass == 0) begin
        check("win_tx_count", 32'(tx_cnt), 32'd512);
        check("win_tx_first", 32'(tx_first), 32'h0400);
        check("win_tx_last", 32'(tx_last), 32'h05FF);
        check("win_start_count", 32'(st_cnt), 32'd1);
        check("win_start_at", 32'(st_at), 32'h0400);
        check("win_end_count", 32'(end_cnt), 32'd1);
        check("win_end_at", 32'(end_at), 32'h05FF);
      end else begin
        check("win_tx_disabled", 32'(tx_cnt), 32'd0);
        check("win_start_disabled", 32'(st_cnt), 32'd0);
        check("win_end_count_rx_only", 32'(end_cnt), 32'd1);
      end
      check("win_rx_count", 32'(rx_cnt), 32'd512);
    end

    // rsttpu mid-frame at 0x0234, with TX slot 1 selected so its window is live.
    tx_slot     = 8'h01;
    tpu_control = 8'h06;
    wait_for(16'h0234, 3000, "halt_reach_234");
    check("halt_win_before", 32'(tx_window), 32'h1);
    tpu_control = 8'h07;
    step();
    check("halt_cnt_zero", 32'(counter), 32'h0);
    check("halt_no_wrap", 32'(frame_wrap), 32'h0);
    check("halt_flag_kept", 32'(int_flag), 32'h1);
    for (int i = 0; i < 3; i++) step();
    check("halt_cnt_held", 32'(counter), 32'h0);
    check("halt_tx_win", 32'(tx_window), 32'h0);
    check("halt_rx_win", 32'(rx_window), 32'h0);

    // last_slot lowered from 5 to 1 at 0x0800: roll through 0xFFFF.
    last_slot   = 7'd5;
    tpu_control = 8'h00;
    step();
    wait_for(16'h0800, 3000, "ls_reach_800");
    last_slot = 7'd1;
    wait_for(16'hFFFF, 70000, "ls_reach_ffff");
    check("ls_no_wrap_at_ffff", 32'(frame_wrap), 32'h0);
    step();
    check("ls_wrap_cnt", 32'(counter), 32'h0);
    check("ls_wrap_pulse", 32'(frame_wrap), 32'h1);
    wait_for(16'h03FF, 1100, "ls_reach_3ff");
    step();
    check("ls_short_wrap_cnt", 32'(counter), 32'h0);
    check("ls_short_wrap_pulse", 32'(frame_wrap), 32'h1);

    // Randomized phase, compared cycle by cycle against the model.
    last_slot = 7'd2;
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      tpu_control = {4'($urandom), 3'($urandom), ($urandom_range(0, 99) == 0)};
      tx_slot     = {1'($urandom), 7'($urandom_range(0, 3))};
      rx_slot     = {1'($urandom), 7'($urandom_range(0, 3))};
      int_clr     = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
